// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter sharing one flop bank between NREQ requesters.
// Each granted operation runs IDLE -> APPLY -> VERIFY and reports DONE/ERR from the readback.
module ff_bank_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = 8,
  parameter string       REGSET = "SET"
) (
  input  logic                   CLK,
  input  logic                   LSR_N,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        OP,
  input  logic [NREQ*WIDTH-1:0]  WDATA,
  output logic [NREQ-1:0]        GNT,
  output logic                   BUSY,
  output logic [WIDTH-1:0]       BANK_DI,
  output logic                   BANK_LSR,
  output logic                   BANK_CE,
  input  logic [WIDTH-1:0]       BANK_Q,
  output logic [WIDTH-1:0]       RDATA,
  output logic                   DONE,
  output logic                   ERR
);

  localparam int unsigned     PtrW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic            SrVal     = (REGSET == "SET");
  localparam logic [WIDTH-1:0] ClearWord = {WIDTH{SrVal}};

  typedef enum logic [1:0] {StIdle, StApply, StVerify} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   g_q, g_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  di_q, di_d;
  logic              lsr_q, lsr_d;
  logic              ce_q, ce_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              found;
  logic [PtrW-1:0]   sel;
  logic [WIDTH-1:0]  sel_data;
  int unsigned       idx;

  // First requester at or after the pointer, wrapping past NREQ-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        sel   = PtrW'(idx);
      end
    end
  end

  assign sel_data = WDATA[32'(sel)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    op_d    = op_q;
    data_d  = data_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    di_d    = '0;
    lsr_d   = 1'b0;
    ce_d    = 1'b0;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          g_d        = sel;
          op_d       = OP[sel];
          data_d     = sel_data;
          gnt_d[sel] = 1'b1;
          busy_d     = 1'b1;
          ce_d       = 1'b1;
          lsr_d      = OP[sel];
          di_d       = OP[sel] ? '0 : sel_data;
          state_d    = StApply;
        end
      end
      StApply: begin
        busy_d  = 1'b1;
        state_d = StVerify;
      end
      StVerify: begin
        rdata_d = BANK_Q;
        err_d   = (BANK_Q != (op_q ? ClearWord : data_q));
        done_d  = 1'b1;
        ptr_d   = (32'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge LSR_N) begin
    if (!LSR_N) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      g_q     <= '0;
      op_q    <= 1'b0;
      data_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      di_q    <= '0;
      lsr_q   <= 1'b0;
      ce_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      op_q    <= op_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      di_q    <= di_d;
      lsr_q   <= lsr_d;
      ce_q    <= ce_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign GNT      = gnt_q;
  assign BUSY     = busy_q;
  assign BANK_DI  = di_q;
  assign BANK_LSR = lsr_q;
  assign BANK_CE  = ce_q;
  assign RDATA    = rdata_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Bench for ff_bank_arbiter: two instances (SET / RESET clear value) with behavioural flop banks,
// a timeline-based reference model checked every cycle, plus directed literal checks.
module tb_ff_bank_arbiter;

  logic        CLK = 1'b0;
  logic        LSR_N = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  op = '0;
  logic [31:0] wdata = '0;
  logic        force_en = 1'b0;
  logic [7:0]  force_val = '0;

  logic [3:0] gnt_a, gnt_b;
  logic       busy_a, busy_b, lsr_a, lsr_b, ce_a, ce_b, done_a, done_b, err_a, err_b;
  logic [7:0] di_a, di_b, rd_a, rd_b, bq_a, bq_b;
  logic [7:0] bank_a = '0;
  logic [7:0] bank_b = '0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ff_bank_arbiter #(.NREQ(4), .WIDTH(8), .REGSET("SET")) u_dut (
    .CLK(CLK), .LSR_N(LSR_N), .REQ(req), .OP(op), .WDATA(wdata), .GNT(gnt_a), .BUSY(busy_a),
    .BANK_DI(di_a), .BANK_LSR(lsr_a), .BANK_CE(ce_a), .BANK_Q(bq_a), .RDATA(rd_a),
    .DONE(done_a), .ERR(err_a)
  );

  ff_bank_arbiter #(.NREQ(4), .WIDTH(8), .REGSET("RESET")) u_dut_rst (
    .CLK(CLK), .LSR_N(LSR_N), .REQ(req), .OP(op), .WDATA(wdata), .GNT(gnt_b), .BUSY(busy_b),
    .BANK_DI(di_b), .BANK_LSR(lsr_b), .BANK_CE(ce_b), .BANK_Q(bq_b), .RDATA(rd_b),
    .DONE(done_b), .ERR(err_b)
  );

  // Flop banks: synchronous set/reset dominates data, capture only with CE.
  always @(posedge CLK) if (ce_a) bank_a <= lsr_a ? 8'hFF : di_a;
  always @(posedge CLK) if (ce_b) bank_b <= lsr_b ? 8'h00 : di_b;
  assign bq_a = force_en ? force_val : bank_a;
  assign bq_b = bank_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each grant schedules its whole output timeline by cycle number.
  int         cyc = 0;
  int         free_at = 0;
  int         ptr_m = 0;
  int         pend_at = 0;
  int         pend_g = 0;
  bit         pend_v = 1'b0;
  int         gsel;
  logic [7:0] pend_exp_a, pend_exp_b, slice_m;
  logic [7:0] q_m;
  logic [7:0] rd_a_m = '0;
  logic [7:0] rd_b_m = '0;
  logic [3:0] e_gnt[int];
  logic [7:0] e_di[int];
  bit         e_busy[int], e_ce[int], e_lsr[int], e_done[int], e_err[int];

  always @(posedge CLK or negedge LSR_N) begin
    if (!LSR_N) begin
      cyc = 0; free_at = 0; ptr_m = 0; pend_v = 1'b0; rd_a_m = '0; rd_b_m = '0;
      e_gnt.delete(); e_di.delete(); e_busy.delete(); e_ce.delete();
      e_lsr.delete(); e_done.delete(); e_err.delete();
    end else begin
      cyc++;
      if (pend_v && cyc == pend_at) begin
        q_m = force_en ? force_val : pend_exp_a;
        rd_a_m = q_m;
        rd_b_m = pend_exp_b;
        e_done[cyc] = 1'b1;
        e_err[cyc] = (q_m != pend_exp_a);
        ptr_m = (pend_g + 1) % 4;
        pend_v = 1'b0;
      end
      if (cyc >= free_at && req != 4'b0) begin
        gsel = -1;
        for (int k = 0; k < 4; k++)
          if (gsel < 0 && req[(ptr_m + k) % 4]) gsel = (ptr_m + k) % 4;
        slice_m = wdata[gsel*8 +: 8];
        e_gnt[cyc] = 4'(1 << gsel);
        e_busy[cyc] = 1'b1;
        e_busy[cyc+1] = 1'b1;
        e_ce[cyc] = 1'b1;
        e_lsr[cyc] = op[gsel];
        e_di[cyc] = op[gsel] ? 8'h00 : slice_m;
        pend_exp_a = op[gsel] ? 8'hFF : slice_m;
        pend_exp_b = op[gsel] ? 8'h00 : slice_m;
        pend_g = gsel;
        pend_at = cyc + 2;
        pend_v = 1'b1;
        free_at = cyc + 3;
      end
    end
  end

  always @(negedge CLK) begin
    logic [3:0] eg;
    logic [7:0] ed;
    bit eb, ec, el, edn, ee;
    eg  = e_gnt.exists(cyc) ? e_gnt[cyc] : 4'h0;
    ed  = e_di.exists(cyc) ? e_di[cyc] : 8'h00;
    eb  = e_busy.exists(cyc) ? e_busy[cyc] : 1'b0;
    ec  = e_ce.exists(cyc) ? e_ce[cyc] : 1'b0;
    el  = e_lsr.exists(cyc) ? e_lsr[cyc] : 1'b0;
    edn = e_done.exists(cyc) ? e_done[cyc] : 1'b0;
    ee  = e_err.exists(cyc) ? e_err[cyc] : 1'b0;
    chk("m_gnt_a", 32'(gnt_a), 32'(eg));   chk("m_gnt_b", 32'(gnt_b), 32'(eg));
    chk("m_di_a", 32'(di_a), 32'(ed));     chk("m_di_b", 32'(di_b), 32'(ed));
    chk("m_busy_a", 32'(busy_a), 32'(eb)); chk("m_busy_b", 32'(busy_b), 32'(eb));
    chk("m_ce_a", 32'(ce_a), 32'(ec));     chk("m_ce_b", 32'(ce_b), 32'(ec));
    chk("m_lsr_a", 32'(lsr_a), 32'(el));   chk("m_lsr_b", 32'(lsr_b), 32'(el));
    chk("m_done_a", 32'(done_a), 32'(edn)); chk("m_done_b", 32'(done_b), 32'(edn));
    chk("m_err_a", 32'(err_a), 32'(ee));   chk("m_err_b", 32'(err_b), 32'(0));
    chk("m_rdata_a", 32'(rd_a), 32'(rd_a_m)); chk("m_rdata_b", 32'(rd_b), 32'(rd_b_m));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    LSR_N = 1'b0;
    #2;
    LSR_N = 1'b1;
  endtask

  logic [3:0] seq2 [3];

  initial begin
    seq2 = '{4'b0001, 4'b0100, 4'b1000};
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt", 32'(gnt_a), 0); chk("rst_busy", 32'(busy_a), 0);
    chk("rst_ce", 32'(ce_a), 0);   chk("rst_rdata", 32'(rd_a), 0);
    chk("rst_done", 32'(done_a), 0);
    LSR_N = 1'b1;

    // Load A5 via requester 0.
    req = 4'b0001; op = 4'b0000; wdata = 32'h0000_00A5;
    tick();
    chk("ld_gnt", 32'(gnt_a), 32'h1); chk("ld_ce", 32'(ce_a), 1); chk("ld_di", 32'(di_a), 32'hA5);
    req = 4'b0000;
    tick();
    chk("ld_ce_off", 32'(ce_a), 0);
    tick();
    chk("ld_done", 32'(done_a), 1); chk("ld_err", 32'(err_a), 0);
    chk("ld_rdata", 32'(rd_a), 32'hA5);

    // Clear via requester 2; WDATA must be ignored.
    req = 4'b0100; op = 4'b0100; wdata = 32'h005A_0000;
    tick();
    chk("clr_gnt", 32'(gnt_a), 32'h4); chk("clr_lsr", 32'(lsr_a), 1);
    chk("clr_di", 32'(di_a), 0);
    req = 4'b0000; op = 4'b0000;
    tick();
    tick();
    chk("clr_rd_set", 32'(rd_a), 32'hFF); chk("clr_rd_reset", 32'(rd_b), 32'h00);
    chk("clr_err_set", 32'(err_a), 0);    chk("clr_err_reset", 32'(err_b), 0);
    tick();
    chk("done_drop", 32'(done_a), 0);

    // Round-robin with all requesters, then requester 1 dropped.
    do_reset();
    req = 4'b1111; wdata = 32'h4433_2211;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("rr_gnt", 32'(gnt_a), (t % 3 == 1) ? (1 << ((t - 1) / 3)) : 0);
      chk("rr_done", 32'(done_a), (t % 3 == 0) ? 1 : 0);
    end
    req = 4'b1101;
    for (int t = 13; t <= 21; t++) begin
      tick();
      chk("rr_skip", 32'(gnt_a), (t % 3 == 1) ? 32'(seq2[(t - 13) / 3]) : 0);
    end
    req = 4'b0000;
    repeat (3) tick();

    // Pointer wrap: 3 then 0.
    do_reset();
    req = 4'b1000;
    tick();
    chk("wrap_first", 32'(gnt_a), 32'h8);
    req = 4'b1001;
    tick();
    tick();
    tick();
    chk("wrap_next", 32'(gnt_a), 32'h1);
    req = 4'b0000;
    repeat (2) tick();

    // Readback mismatch on the SET instance only.
    force_en = 1'b1; force_val = 8'h00;
    req = 4'b0001; op = 4'b0000; wdata = 32'h0000_003C;
    tick();
    req = 4'b0000;
    tick();
    tick();
    chk("mm_done", 32'(done_a), 1); chk("mm_err", 32'(err_a), 1); chk("mm_rdata", 32'(rd_a), 0);
    chk("mm_err_b", 32'(err_b), 0); chk("mm_rdata_b", 32'(rd_b), 32'h3C);
    force_en = 1'b0;

    // Async reset during APPLY.
    req = 4'b0010;
    tick();
    chk("ar_gnt_pre", 32'(gnt_a), 32'h2);
    #2 LSR_N = 1'b0;
    #1;
    chk("ar_ce", 32'(ce_a), 0); chk("ar_gnt", 32'(gnt_a), 0); chk("ar_busy", 32'(busy_a), 0);
    #3 LSR_N = 1'b1;
    req = 4'b0000;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("ar_no_done", 32'(done_a), 0);
    end
    req = 4'b0101;
    tick();
    chk("ar_ptr0", 32'(gnt_a), 32'h1);
    req = 4'b0000;
    repeat (2) tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      req = 4'($urandom_range(0, 15));
      op = 4'($urandom_range(0, 15));
      wdata = $urandom;
      force_en = ($urandom_range(0, 7) == 0);
      force_val = 8'($urandom);
      if (i % 200 == 100) begin
        #3 LSR_N = 1'b0;
        #3 LSR_N = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
